// File: rtl/aibcr3aux_osc_pkg.sv
// Shared definitions for the AIB aux oscillator clock-gate controller:
// FSM state encoding and default wake/hold timing.
package aibcr3aux_osc_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } osc_state_e;

  localparam int unsigned WAKE_CYC_DEF = 4;
  localparam int unsigned HOLD_CYC_DEF = 16;

  // Counter width covering the larger of the two timing windows (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/aibcr3aux_osc_clkgate_cnt.sv
// Loadable down-counter with zero flag; timing base for the wake and hold windows.
// Load has priority over decrement and the count never wraps below zero.
module aibcr3aux_osc_clkgate_cnt
  import aibcr3aux_osc_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          ckin,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero_c
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge ckin or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/aibcr3aux_osc_clkgate_ctrl.sv
// Oscillator clock-gate controller: wakes the gate on any request, grants per requester,
// and drops the enable after an idle hold window. Define AIBCR3AUX_OSC_CLKGATE_CNT_EN for gate_cnt.
module aibcr3aux_osc_clkgate_ctrl
  import aibcr3aux_osc_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WAKE_CYC = WAKE_CYC_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic            ckin,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            force_on,
  output logic            en,
  output logic [NREQ-1:0] ack,
  output logic            busy,
  output logic [1:0]      state,
  output logic [15:0]     gate_cnt
);

  localparam int unsigned CW = cnt_width(WAKE_CYC, HOLD_CYC);

  osc_state_e      r_state;
  osc_state_e      w_next;
  logic            r_en;
  logic            r_busy;
  logic [NREQ-1:0] r_ack;
  logic            w_any_req;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic            w_dec;
  logic            w_zero;

  assign w_any_req = |req;

  // Next state and counter control; a load of zero parks the counter in OFF/ON.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_load = 1'b1;
        if (w_any_req) begin
          w_next     = ST_WAKE;
          w_load_val = CW'(WAKE_CYC - 1);
        end
      end
      ST_WAKE: begin
        if (w_zero) w_next = ST_ON;
        else        w_dec  = 1'b1;
      end
      ST_ON: begin
        w_load = 1'b1;
        if (!w_any_req) begin
          w_next     = ST_HOLD;
          w_load_val = CW'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (w_any_req) begin
          w_next = ST_ON;
          w_load = 1'b1;
        end else if (w_zero) begin
          w_next = ST_OFF;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_next = ST_OFF;
    endcase
  end

  // Outputs are registered from the next state so en/ack are glitch-free.
  always_ff @(posedge ckin or posedge rst) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_next;
      r_en    <= (w_next != ST_OFF) | force_on;
      r_busy  <= (w_next != ST_OFF);
      r_ack   <= req & {NREQ{w_next == ST_ON}};
    end
  end

  aibcr3aux_osc_clkgate_cnt #(
    .CW (CW)
  ) u_cnt (
    .ckin       (ckin),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero_c   (w_zero)
  );

`ifdef AIBCR3AUX_OSC_CLKGATE_CNT_EN
  logic [15:0] r_gate_cnt;
  logic        w_wake_start;

  assign w_wake_start = (r_state == ST_OFF) && (w_next == ST_WAKE);

  // Saturating count of OFF->WAKE events.
  always_ff @(posedge ckin or posedge rst) begin
    if (rst) begin
      r_gate_cnt <= '0;
    end else if (w_wake_start && (r_gate_cnt != 16'hFFFF)) begin
      r_gate_cnt <= r_gate_cnt + 16'd1;
    end
  end

  assign gate_cnt = r_gate_cnt;
`else
  assign gate_cnt = '0;
`endif

  assign en    = r_en;
  assign ack   = r_ack;
  assign busy  = r_busy;
  assign state = r_state;

endmodule

// File: tb/tb_aibcr3aux_osc_clkgate_ctrl.sv
// Directed bench for the oscillator clock-gate controller (defaults NREQ=4, WAKE=4, HOLD=16).
module tb_aibcr3aux_osc_clkgate_ctrl;

  logic        ckin;
  logic        rst;
  logic [3:0]  req;
  logic        force_on;
  logic        en;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  state;
  logic [15:0] gate_cnt;

  int total = 0;
  int bad   = 0;

  aibcr3aux_osc_clkgate_ctrl dut (
    .ckin     (ckin),
    .rst      (rst),
    .req      (req),
    .force_on (force_on),
    .en       (en),
    .ack      (ack),
    .busy     (busy),
    .state    (state),
    .gate_cnt (gate_cnt)
  );

  initial ckin = 1'b0;
  always #5 ckin = ~ckin;

  task automatic step();
    @(posedge ckin);
    #1;
  endtask

  // Return to OFF with requests dropped, bounded.
  task automatic go_off();
    int n;
    req = 4'b0000;
    n = 0;
    while (state !== 2'd0 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL go_off_timeout got=%0d exp=0", state); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; force_on = 1'b0;
    step(); step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_en got=%0b exp=0", en); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rst_ack got=%0b exp=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (gate_cnt !== 16'd0) begin bad++; $display("FAIL rst_gate_cnt got=%0d exp=0", gate_cnt); end
    rst = 1'b0;
    step();
    total++; if (en !== 1'b0) begin bad++; $display("FAIL idle_en got=%0b exp=0", en); end
  endtask

  task automatic test_wake();
    req = 4'b0001;
    step();
    total++; if (state !== 2'd1 || en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL wake_enter got=st%0d en%0b busy%0b exp=st1 en1 busy1", state, en, busy);
    end
    for (int i = 1; i < 4; i++) begin
      step();
      total++; if (state !== 2'd1 || ack !== 4'b0000) begin
        bad++; $display("FAIL wake_cyc%0d got=st%0d ack%0b exp=st1 ack0", i, state, ack);
      end
    end
    step();
    total++; if (state !== 2'd2 || ack !== 4'b0001) begin
      bad++; $display("FAIL wake_on got=st%0d ack%0b exp=st2 ack0001", state, ack);
    end
  endtask

  task automatic test_hold();
    req = 4'b0000;
    step();
    total++; if (state !== 2'd3 || ack !== 4'b0000 || en !== 1'b1) begin
      bad++; $display("FAIL hold_enter got=st%0d ack%0b en%0b exp=st3 ack0 en1", state, ack, en);
    end
    for (int i = 1; i < 16; i++) begin
      step();
      total++; if (state !== 2'd3 || en !== 1'b1) begin
        bad++; $display("FAIL hold_cyc%0d got=st%0d en%0b exp=st3 en1", i, state, en);
      end
    end
    step();
    total++; if (state !== 2'd0 || en !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_off got=st%0d en%0b busy%0b exp=st0 en0 busy0", state, en, busy);
    end
  endtask

  task automatic test_hold_rescue();
    logic en_dropped;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    req = 4'b0000;
    step();
    en_dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (en !== 1'b1) en_dropped = 1'b1;
    end
    req = 4'b0010;
    step();
    total++; if (state !== 2'd2 || ack !== 4'b0010) begin
      bad++; $display("FAIL rescue_on got=st%0d ack%0b exp=st2 ack0010", state, ack);
    end
    total++; if (en_dropped !== 1'b0 || en !== 1'b1) begin
      bad++; $display("FAIL rescue_en got=dropped%0b en%0b exp=dropped0 en1", en_dropped, en);
    end
    req = 4'b0011;
    step();
    total++; if (ack !== 4'b0011) begin bad++; $display("FAIL ack_both got=%0b exp=0011", ack); end
    req = 4'b0010;
    step();
    total++; if (ack !== 4'b0010 || state !== 2'd2) begin
      bad++; $display("FAIL ack_indep got=ack%0b st%0d exp=ack0010 st2", ack, state);
    end
    // Request arriving in the last hold cycle must win over the timeout.
    req = 4'b0000;
    step();
    for (int i = 1; i < 16; i++) step();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL hold_last got=%0d exp=3", state); end
    req = 4'b0001;
    step();
    total++; if (state !== 2'd2 || ack !== 4'b0001 || en !== 1'b1) begin
      bad++; $display("FAIL hold_race got=st%0d ack%0b en%0b exp=st2 ack0001 en1", state, ack, en);
    end
    go_off();
  endtask

  task automatic test_pulse();
    logic saw_ack;
    saw_ack = 1'b0;
    req = 4'b0001;
    step();
    req = 4'b0000;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL pulse_wake got=%0d exp=1", state); end
    for (int i = 1; i < 4; i++) begin
      step();
      if (ack !== 4'b0000) saw_ack = 1'b1;
    end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL pulse_wake_full got=%0d exp=1", state); end
    step();
    if (ack !== 4'b0000) saw_ack = 1'b1;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL pulse_on got=%0d exp=2", state); end
    step();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL pulse_hold got=%0d exp=3", state); end
    for (int i = 1; i < 16; i++) begin
      step();
      if (ack !== 4'b0000) saw_ack = 1'b1;
    end
    total++; if (state !== 2'd3 || en !== 1'b1) begin
      bad++; $display("FAIL pulse_hold_end got=st%0d en%0b exp=st3 en1", state, en);
    end
    step();
    total++; if (state !== 2'd0 || en !== 1'b0) begin
      bad++; $display("FAIL pulse_off got=st%0d en%0b exp=st0 en0", state, en);
    end
    total++; if (saw_ack !== 1'b0) begin bad++; $display("FAIL pulse_noack got=%0b exp=0", saw_ack); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_cnt;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) step();
    total++; if (state !== 2'd2 || ack !== 4'b1111) begin
      bad++; $display("FAIL mid_on got=st%0d ack%0b exp=st2 ack1111", state, ack);
    end
    rst = 1'b1;
    #1;
    total++; if (en !== 1'b0 || ack !== 4'b0000 || state !== 2'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async got=en%0b ack%0b st%0d busy%0b exp=0 0 0 0", en, ack, state, busy);
    end
    step();
    rst = 1'b0;
    step();
    total++; if (state !== 2'd1 || en !== 1'b1) begin
      bad++; $display("FAIL mid_rewake got=st%0d en%0b exp=st1 en1", state, en);
    end
    for (int i = 1; i < 4; i++) step();
    total++; if (state !== 2'd1 || ack !== 4'b0000) begin
      bad++; $display("FAIL mid_rewake_full got=st%0d ack%0b exp=st1 ack0", state, ack);
    end
    step();
    total++; if (state !== 2'd2 || ack !== 4'b1111) begin
      bad++; $display("FAIL mid_reon got=st%0d ack%0b exp=st2 ack1111", state, ack);
    end
`ifdef AIBCR3AUX_OSC_CLKGATE_CNT_EN
    exp_cnt = 16'd1;
`else
    exp_cnt = 16'd0;
`endif
    total++; if (gate_cnt !== exp_cnt) begin
      bad++; $display("FAIL mid_gate_cnt got=%0d exp=%0d", gate_cnt, exp_cnt);
    end
    go_off();
  endtask

  task automatic test_force();
    req = 4'b0000;
    force_on = 1'b1;
    step();
    total++; if (en !== 1'b1 || state !== 2'd0 || busy !== 1'b0 || ack !== 4'b0000) begin
      bad++; $display("FAIL force got=en%0b st%0d busy%0b ack%0b exp=en1 st0 busy0 ack0", en, state, busy, ack);
    end
    step();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL force_hold got=%0d exp=0", state); end
    force_on = 1'b0;
    step();
    total++; if (en !== 1'b0) begin bad++; $display("FAIL force_release got=%0b exp=0", en); end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_hold();
    test_hold_rescue();
    test_pulse();
    test_reset_mid();
    test_force();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
